// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one synchronous-FIFO write port between NREQ requesters.
// Grants one owner for a burst of up to MAX_BURST words and counts full-stalled cycles.
module fifo_wr_arbiter #(
   parameter int WIDTH     = 8,
   parameter int NREQ      = 4,
   parameter int MAX_BURST = 4
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic [NREQ-1:0]          req_i,
   input  logic [NREQ*WIDTH-1:0]    wdata_i,
   output logic [NREQ-1:0]          ack_o,
   input  logic                     fifo_full_i,
   output logic                     fifo_wr_en_o,
   output logic [WIDTH-1:0]         fifo_wdata_o,
   output logic [$clog2(NREQ)-1:0]  owner_o,
   output logic                     busy_o,
   output logic [15:0]              stall_cnt_o
);

   localparam int OW = $clog2(NREQ);
   localparam logic [3:0] BURST_LIMIT = 4'(MAX_BURST);

   typedef enum logic {
      S_IDLE,
      S_GRANT
   } state_t;

   state_t         state_q, state_d;
   logic [OW-1:0]  owner_q, owner_d;
   logic [OW-1:0]  last_q, last_d;
   logic [3:0]     burst_q, burst_d;
   logic [15:0]    stall_q, stall_d;

   logic [OW-1:0]    sel;
   logic             req_own;
   logic [WIDTH-1:0] lane_data;
   logic             accept;

   // Round-robin pick: lowest requester above last wins; otherwise wrap to the lowest overall.
   always_comb begin
      sel = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         if (req_i[k]) sel = OW'(k);
      end
      for (int k = NREQ - 1; k >= 0; k--) begin
         if (req_i[k] && (OW'(k) > last_q)) sel = OW'(k);
      end
   end

   // Owner lane selection with constant indices only, so non-power-of-two NREQ stays in range.
   always_comb begin
      req_own   = 1'b0;
      lane_data = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (owner_q == OW'(k)) begin
            req_own   = req_i[k];
            lane_data = wdata_i[k*WIDTH +: WIDTH];
         end
      end
   end

   assign accept = (state_q == S_GRANT) && req_own && !fifo_full_i;

   always_comb begin
      ack_o = '0;
      for (int k = 0; k < NREQ; k++) begin
         ack_o[k] = accept && (owner_q == OW'(k));
      end
   end

   assign fifo_wr_en_o = accept;
   assign fifo_wdata_o = accept ? lane_data : '0;
   assign owner_o      = owner_q;
   assign busy_o       = (state_q == S_GRANT);
   assign stall_cnt_o  = stall_q;

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can infer a latch.
      state_d = state_q;
      owner_d = owner_q;
      last_d  = last_q;
      burst_d = burst_q;
      stall_d = stall_q;
      unique case (state_q)
         S_IDLE: begin
            if (|req_i) begin
               state_d = S_GRANT;
               owner_d = sel;
               last_d  = sel;
               burst_d = '0;
            end
         end
         S_GRANT: begin
            if (!req_own) begin
               state_d = S_IDLE;
            end else if (fifo_full_i) begin
               if (stall_q != 16'hFFFF) stall_d = stall_q + 16'd1;
            end else begin
               burst_d = burst_q + 4'd1;
               if ((burst_q + 4'd1) == BURST_LIMIT) state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // last resets to NREQ-1 so requester 0 has first priority after reset.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= S_IDLE;
         owner_q <= '0;
         last_q  <= OW'(NREQ - 1);
         burst_q <= '0;
         stall_q <= '0;
      end else begin
         // NOTE: non-blocking assignments keep every register sampling pre-edge values.
         state_q <= state_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         burst_q <= burst_d;
         stall_q <= stall_d;
      end
   end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: directed requester scenarios push expected writes,
// a negedge monitor pops and compares cycle, owner, ack and data on every FIFO write.
module tb_fifo_wr_arbiter;

   localparam int WIDTH     = 8;
   localparam int NREQ      = 4;
   localparam int MAX_BURST = 4;
   localparam int OW        = $clog2(NREQ);

   logic                    clk_i = 1'b0;
   logic                    rst_ni = 1'b1;
   logic [NREQ-1:0]         req_i = '0;
   logic [NREQ*WIDTH-1:0]   wdata_i = '0;
   logic [NREQ-1:0]         ack_o;
   logic                    fifo_full_i = 1'b0;
   logic                    fifo_wr_en_o;
   logic [WIDTH-1:0]        fifo_wdata_o;
   logic [OW-1:0]           owner_o;
   logic                    busy_o;
   logic [15:0]             stall_cnt_o;

   fifo_wr_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .MAX_BURST(MAX_BURST)) dut (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .req_i        (req_i),
      .wdata_i      (wdata_i),
      .ack_o        (ack_o),
      .fifo_full_i  (fifo_full_i),
      .fifo_wr_en_o (fifo_wr_en_o),
      .fifo_wdata_o (fifo_wdata_o),
      .owner_o      (owner_o),
      .busy_o       (busy_o),
      .stall_cnt_o  (stall_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   int cyc = 0;
   always @(posedge clk_i) cyc <= cyc + 1;

   typedef struct {
      int rel;
      int owner;
      int data;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   t0       = 0;

   // Requester model: each lane offers 16*k + word index while it has words left.
   int   left[NREQ];
   int   idx[NREQ];
   int   start[NREQ];
   int   full_cnt, full_len, trig_lane, trig_idx;
   logic full_hold;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic exp_push(input int rel, input int owner, input int data);
      exp_t e;
      e.rel   = rel;
      e.owner = owner;
      e.data  = data;
      exp_q.push_back(e);
   endtask

   task automatic clear_model();
      for (int k = 0; k < NREQ; k++) begin
         left[k]  = 0;
         idx[k]   = 0;
         start[k] = 0;
      end
      full_cnt  = 0;
      full_len  = 0;
      trig_lane = -1;
      trig_idx  = 0;
      full_hold = 1'b0;
   endtask

   task automatic apply();
      int rel;
      rel = cyc - t0;
      for (int k = 0; k < NREQ; k++) begin
         req_i[k] = (rel >= start[k]) && (left[k] > 0);
         wdata_i[k*WIDTH +: WIDTH] = 8'(16 * k + idx[k]);
      end
      fifo_full_i = full_hold || (full_cnt > 0);
      if (full_cnt > 0) full_cnt--;
   endtask

   task automatic observe();
      for (int k = 0; k < NREQ; k++) begin
         if (ack_o[k]) begin
            idx[k]++;
            left[k]--;
            if (k == trig_lane && idx[k] == trig_idx) full_cnt = full_len;
         end
      end
   endtask

   task automatic run(input int n);
      repeat (n) begin
         apply();
         @(negedge clk_i);
         observe();
         @(posedge clk_i);
         #1;
      end
   endtask

   task automatic start_test();
      @(posedge clk_i);
      #1;
      t0 = cyc;
   endtask

   task automatic check_quiet(input string tag);
      check({tag, "_ack"},   ack_o, 0);
      check({tag, "_wr_en"}, fifo_wr_en_o, 0);
      check({tag, "_wdata"}, fifo_wdata_o, 0);
      check({tag, "_busy"},  busy_o, 0);
      check({tag, "_owner"}, owner_o, 0);
   endtask

   task automatic do_reset();
      rst_ni = 1'b0;
      clear_model();
      req_i       = '0;
      wdata_i     = '0;
      fifo_full_i = 1'b0;
      #1;
      check_quiet("rst_async");
      repeat (2) @(posedge clk_i);
      #1;
      check_quiet("rst_hold");
      check("rst_stall", stall_cnt_o, 0);
      rst_ni = 1'b1;
   endtask

   // Monitor: decoupled from stimulus, runs on the falling edge.
   always @(negedge clk_i) begin : monitor
      exp_t            e;
      logic [NREQ-1:0] exp_ack;
      if (rst_ni) begin
         if (!busy_o) check("idle_no_wr", fifo_wr_en_o, 0);
         if (fifo_wr_en_o) begin
            check("wr_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               exp_ack = '0;
               exp_ack[e.owner] = 1'b1;
               check("wr_cycle", cyc - t0, e.rel);
               check("wr_ack",   ack_o, exp_ack);
               check("wr_owner", owner_o, e.owner);
               check("wr_data",  fifo_wdata_o, e.data);
            end
         end else begin
            check("no_wr_ack_zero", ack_o, 0);
         end
      end
   end

   initial begin
      #1;
      do_reset();

      // 1: requester 0 alone, 6 words, bursts of 4 then 2.
      left[0] = 6;
      for (int w = 0; w < 4; w++) exp_push(1 + w, 0, w);
      exp_push(6, 0, 4);
      exp_push(7, 0, 5);
      start_test();
      run(12);
      check("t1_drain", exp_q.size(), 0);

      // 2: all requesting; owners 0,1,2,3,0 with 4 words each.
      do_reset();
      left[0] = 8;
      left[1] = 4;
      left[2] = 4;
      left[3] = 4;
      for (int b = 0; b < 5; b++) begin
         for (int w = 0; w < 4; w++) begin
            exp_push(5 * b + 1 + w, b % 4, 16 * (b % 4) + ((b == 4) ? 4 + w : w));
         end
      end
      start_test();
      run(30);
      check("t2_drain", exp_q.size(), 0);

      // 3: full for 3 cycles after owner 1's second word.
      do_reset();
      left[1]   = 4;
      trig_lane = 1;
      trig_idx  = 2;
      full_len  = 3;
      exp_push(1, 1, 8'h10);
      exp_push(2, 1, 8'h11);
      exp_push(6, 1, 8'h12);
      exp_push(7, 1, 8'h13);
      start_test();
      run(6);
      check("t3_stall_3", stall_cnt_o, 3);
      run(6);
      check("t3_idle_after", busy_o, 0);
      check("t3_stall_held", stall_cnt_o, 3);
      check("t3_drain", exp_q.size(), 0);

      // 4: owner 2 drops after one word while 0 and 3 wait; next owners 3 then 0.
      do_reset();
      left[2]  = 1;
      left[0]  = 4;
      start[0] = 1;
      left[3]  = 4;
      start[3] = 1;
      exp_push(1, 2, 8'h20);
      for (int w = 0; w < 4; w++) exp_push(4 + w, 3, 8'h30 + w);
      for (int w = 0; w < 4; w++) exp_push(9 + w, 0, w);
      start_test();
      run(16);
      check("t4_drain", exp_q.size(), 0);

      // 5: reset mid-burst (owner 1, 2 words done), then all requesting.
      do_reset();
      left[1] = 4;
      exp_push(1, 1, 8'h10);
      exp_push(2, 1, 8'h11);
      start_test();
      run(3);
      apply();
      #1;
      check("t5_pre_rst_wr", fifo_wr_en_o, 1);
      rst_ni = 1'b0;
      #1;
      check_quiet("t5_async");
      check("t5_drain_pre", exp_q.size(), 0);
      do_reset();
      for (int k = 0; k < NREQ; k++) left[k] = 4;
      for (int b = 0; b < 4; b++) begin
         for (int w = 0; w < 4; w++) exp_push(5 * b + 1 + w, b, 16 * b + w);
      end
      start_test();
      run(24);
      check("t5_drain", exp_q.size(), 0);

      // 6: full held with owner 0 requesting; stall counter saturates.
      do_reset();
      left[0]   = 1;
      full_hold = 1'b1;
      start_test();
      run(101);
      check("t6_stall_100", stall_cnt_o, 100);
      run(70000 - 101);
      check("t6_stall_sat", stall_cnt_o, 16'hFFFF);
      full_hold = 1'b0;
      exp_push(70000, 0, 8'h00);
      run(3);
      check("t6_stall_final", stall_cnt_o, 16'hFFFF);
      check("t6_idle_after", busy_o, 0);
      check("t6_drain", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
